// File: rtl/template_list_serializer_if.sv
// Word-in / byte-out bundle of the template list serializer.
interface template_list_serializer_if #(
    parameter int unsigned CHAR_BITS      = 8,
    parameter int unsigned WORD_MAX_LEN   = 8,
    parameter int unsigned RANGES_MAX     = 4,
    parameter int unsigned RANGE_INFO_MSB = $clog2(WORD_MAX_LEN)
);
    localparam int unsigned DIN_W   = WORD_MAX_LEN * CHAR_BITS;
    localparam int unsigned RANGE_W = RANGES_MAX * (RANGE_INFO_MSB + 1);

    logic [DIN_W-1:0]   din;
    logic [RANGE_W-1:0] range_info;
    logic               is_template_list;
    logic               word_list_end;
    logic               wr_en;
    logic               full;
    logic [7:0]         dout;
    logic               dout_wr_en;
    logic               dout_full;
    logic               pkt_end;

    // Word source / byte sink side.
    modport master (
        output din, range_info, is_template_list, word_list_end, wr_en, dout_full,
        input  full, dout, dout_wr_en, pkt_end
    );

    // Serializer side.
    modport slave (
        input  din, range_info, is_template_list, word_list_end, wr_en, dout_full,
        output full, dout, dout_wr_en, pkt_end
    );
endinterface

// File: rtl/template_list_serializer.sv
// Serializes one parallel word (+ optional RANGE_INFO records) into the byte
// stream parsed by the template/word list receiver.
module template_list_serializer #(
    parameter int unsigned CHAR_BITS      = 8,
    parameter int unsigned WORD_MAX_LEN   = 8,
    parameter int unsigned RANGES_MAX     = 4,
    parameter int unsigned RANGE_INFO_MSB = $clog2(WORD_MAX_LEN)
) (
    input logic                        clk,
    input logic                        rst,
    template_list_serializer_if.slave  bus
);
    localparam int unsigned REC_W = RANGE_INFO_MSB + 1;
    localparam int unsigned CNT_W = (WORD_MAX_LEN > 1) ? $clog2(WORD_MAX_LEN) : 1;
    localparam int unsigned RCN_W = (RANGES_MAX > 1) ? $clog2(RANGES_MAX) : 1;
    localparam logic [CNT_W-1:0] CHAR_LAST = CNT_W'(WORD_MAX_LEN - 1);
    localparam logic [RCN_W-1:0] REC_LAST  = RCN_W'(RANGES_MAX - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WORD  = 2'd1,
        ST_RANGE = 2'd2
    } state_e;

    state_e               state_q, state_d;
    logic                 full_q, full_d;
    logic [7:0]           dout_q, dout_d;
    logic                 dout_wr_en_q, dout_wr_en_d;
    logic                 pkt_end_q, pkt_end_d;
    logic [CHAR_BITS-1:0] chars_q [WORD_MAX_LEN];
    logic [CHAR_BITS-1:0] chars_d [WORD_MAX_LEN];
    logic [REC_W-1:0]     recs_q  [RANGES_MAX];
    logic [REC_W-1:0]     recs_d  [RANGES_MAX];
    logic                 tmpl_q, tmpl_d;
    logic                 last_q, last_d;
    logic [CNT_W-1:0]     char_cnt_q, char_cnt_d;
    logic [RCN_W-1:0]     rec_cnt_q, rec_cnt_d;

    logic [CHAR_BITS-1:0] cur_char;
    logic [REC_W-1:0]     cur_rec;
    logic [7:0]           rec_byte;

    // Current character/record and the wire format of a RANGE_INFO byte.
    always_comb begin
        cur_char = chars_q[char_cnt_q];
        cur_rec  = recs_q[rec_cnt_q];
        rec_byte = '0;
        rec_byte[7] = cur_rec[RANGE_INFO_MSB];
        rec_byte[RANGE_INFO_MSB-1:0] = cur_rec[RANGE_INFO_MSB-1:0];
    end

    // Next-state, latch capture and output byte selection.
    always_comb begin
        state_d      = state_q;
        dout_d       = dout_q;
        dout_wr_en_d = 1'b0;
        pkt_end_d    = 1'b0;
        chars_d      = chars_q;
        recs_d       = recs_q;
        tmpl_d       = tmpl_q;
        last_d       = last_q;
        char_cnt_d   = char_cnt_q;
        rec_cnt_d    = rec_cnt_q;

        unique case (state_q)
            ST_IDLE: begin
                if (bus.wr_en) begin
                    for (int i = 0; i < int'(WORD_MAX_LEN); i++) begin
                        chars_d[i] = bus.din[i*CHAR_BITS +: CHAR_BITS];
                    end
                    for (int j = 0; j < int'(RANGES_MAX); j++) begin
                        recs_d[j] = bus.range_info[j*REC_W +: REC_W];
                    end
                    tmpl_d     = bus.is_template_list;
                    last_d     = bus.word_list_end;
                    char_cnt_d = '0;
                    rec_cnt_d  = '0;
                    state_d    = ST_WORD;
                end
            end
            ST_WORD: begin
                if (!bus.dout_full) begin
                    dout_wr_en_d = 1'b1;
                    dout_d       = 8'(cur_char);
                    // A zero char is the terminator; a full-length word has none.
                    if ((cur_char == '0) || (char_cnt_q == CHAR_LAST)) begin
                        if (tmpl_q) begin
                            state_d = ST_RANGE;
                        end else begin
                            state_d   = ST_IDLE;
                            pkt_end_d = last_q;
                        end
                    end else begin
                        char_cnt_d = char_cnt_q + CNT_W'(1);
                    end
                end
            end
            ST_RANGE: begin
                if (!bus.dout_full) begin
                    dout_wr_en_d = 1'b1;
                    dout_d       = rec_byte;
                    if ((cur_rec == '0) || (rec_cnt_q == REC_LAST)) begin
                        state_d   = ST_IDLE;
                        pkt_end_d = last_q;
                    end else begin
                        rec_cnt_d = rec_cnt_q + RCN_W'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        full_d = (state_d != ST_IDLE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            full_q       <= 1'b0;
            dout_q       <= '0;
            dout_wr_en_q <= 1'b0;
            pkt_end_q    <= 1'b0;
            for (int i = 0; i < int'(WORD_MAX_LEN); i++) chars_q[i] <= '0;
            for (int j = 0; j < int'(RANGES_MAX); j++) recs_q[j] <= '0;
            tmpl_q       <= 1'b0;
            last_q       <= 1'b0;
            char_cnt_q   <= '0;
            rec_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            full_q       <= full_d;
            dout_q       <= dout_d;
            dout_wr_en_q <= dout_wr_en_d;
            pkt_end_q    <= pkt_end_d;
            chars_q      <= chars_d;
            recs_q       <= recs_d;
            tmpl_q       <= tmpl_d;
            last_q       <= last_d;
            char_cnt_q   <= char_cnt_d;
            rec_cnt_q    <= rec_cnt_d;
        end
    end

    assign bus.full       = full_q;
    assign bus.dout       = dout_q;
    assign bus.dout_wr_en = dout_wr_en_q;
    assign bus.pkt_end    = pkt_end_q;
endmodule

// File: tb/tb_template_list_serializer.sv
// Scoreboard bench for template_list_serializer: directed cases plus random words.
module tb_template_list_serializer;
    localparam int unsigned CB   = 8;
    localparam int unsigned WML  = 8;
    localparam int unsigned RM   = 4;
    localparam int unsigned RMSB = 3;

    typedef struct packed {
        logic [7:0] b;
        logic       e;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    template_list_serializer_if #(.CHAR_BITS(CB), .WORD_MAX_LEN(WML),
                                  .RANGES_MAX(RM), .RANGE_INFO_MSB(RMSB)) bus ();

    template_list_serializer #(.CHAR_BITS(CB), .WORD_MAX_LEN(WML),
                               .RANGES_MAX(RM), .RANGE_INFO_MSB(RMSB)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    exp_t          sb[$];
    int            checks = 0;
    int            errors = 0;
    bit            stall_en = 1'b0;
    logic          force_full = 1'b0;
    logic [CB-1:0] ch [WML];
    logic [RMSB:0] rg [RM];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Downstream backpressure: random when enabled, otherwise directed.
    always @(negedge clk) begin
        bus.dout_full = stall_en ? ($urandom_range(0, 3) == 0) : force_full;
    end

    // Monitor: every written byte must match the head of the scoreboard.
    always @(negedge clk) begin
        if (bus.dout_wr_en === 1'b1) begin
            if (sb.size() == 0) begin
                chk("unexpected_byte", {23'd0, bus.dout, bus.pkt_end}, 32'hDEAD);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("byte_pkt_end", {23'd0, bus.dout, bus.pkt_end}, {23'd0, e.b, e.e});
            end
        end
    end

    // Reference model: byte list built straight from the word/record rules.
    task automatic model(input bit tmpl, input bit last);
        logic [7:0] q[$];
        for (int i = 0; i < int'(WML); i++) begin
            if (ch[i] == 0) begin
                q.push_back(8'h00);
                break;
            end
            q.push_back(8'(ch[i]));
        end
        if (tmpl) begin
            for (int j = 0; j < int'(RM); j++) begin
                int r;
                r = int'(rg[j]);
                if (r == 0) begin
                    q.push_back(8'h00);
                    break;
                end
                q.push_back(8'((r >> RMSB) * 128 + (r % (1 << RMSB))));
            end
        end
        for (int k = 0; k < q.size(); k++) begin
            exp_t e;
            e.b = q[k];
            e.e = last && (k == q.size() - 1);
            sb.push_back(e);
        end
    endtask

    task automatic wait_not_full();
        int n = 0;
        while (bus.full !== 1'b0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (n >= 500) chk("wait_not_full_timeout", {31'd0, bus.full}, 32'd0);
    endtask

    // Issue one word (called at a negedge); holds wr_en one extra cycle with junk to test ignore-while-full.
    task automatic send_word(input bit tmpl, input bit last, input bit chk_lat);
        wait_not_full();
        for (int i = 0; i < int'(WML); i++) bus.din[i*CB +: CB] = ch[i];
        for (int j = 0; j < int'(RM); j++) bus.range_info[j*(RMSB+1) +: (RMSB+1)] = rg[j];
        bus.is_template_list = tmpl;
        bus.word_list_end    = last;
        bus.wr_en            = 1'b1;
        model(tmpl, last);
        @(posedge clk);
        @(negedge clk);
        chk("full_after_accept", {31'd0, bus.full}, 32'd1);
        if (chk_lat) chk("no_byte_before_latency", {31'd0, bus.dout_wr_en}, 32'd0);
        bus.din              = {$urandom, $urandom};
        bus.range_info       = 16'($urandom);
        bus.is_template_list = 1'($urandom);
        bus.word_list_end    = 1'($urandom);
        @(negedge clk);
        bus.wr_en = 1'b0;
        if (chk_lat) chk("first_byte_latency", {31'd0, bus.dout_wr_en}, 32'd1);
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk("drain_empty", sb.size(), 32'd0);
        @(negedge clk);
        chk("idle_not_full", {31'd0, bus.full}, 32'd0);
    endtask

    task automatic set_word(input string s);
        for (int i = 0; i < int'(WML); i++) ch[i] = (i < s.len()) ? CB'(s[i]) : '0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        bus.wr_en = 1'b0;
        bus.din = '0;
        bus.range_info = '0;
        bus.is_template_list = 1'b0;
        bus.word_list_end = 1'b0;
        for (int j = 0; j < int'(RM); j++) rg[j] = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_full", {31'd0, bus.full}, 32'd0);
        chk("reset_dout", {24'd0, bus.dout}, 32'd0);
        chk("reset_dout_wr_en", {31'd0, bus.dout_wr_en}, 32'd0);
        chk("reset_pkt_end", {31'd0, bus.pkt_end}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // 1: short word with terminator
        set_word("abc");
        send_word(1'b0, 1'b0, 1'b1);
        drain();
        // 2: full-length last word, no terminator
        set_word("abcdefgh");
        send_word(1'b0, 1'b1, 1'b1);
        drain();
        // 3: template word with a record terminator
        set_word("ab");
        rg[0] = 4'h3; rg[1] = 4'hF; rg[2] = 4'h0; rg[3] = 4'h5;
        send_word(1'b1, 1'b1, 1'b1);
        drain();
        // 4: zero-length template word, all records used (junk after the zero char)
        set_word("");
        ch[1] = 8'h41; ch[2] = 8'h42;
        rg[0] = 4'h1; rg[1] = 4'h2; rg[2] = 4'h3; rg[3] = 4'h4;
        send_word(1'b1, 1'b0, 1'b1);
        drain();
        // 5: 3-cycle downstream stall mid-word
        set_word("abcdefgh");
        send_word(1'b0, 1'b0, 1'b1);
        force_full = 1'b1;
        repeat (3) @(negedge clk);
        force_full = 1'b0;
        drain();
        // 6: reset while emitting RANGE bytes, with a simultaneous wr_en
        set_word("a");
        rg[0] = 4'h1; rg[1] = 4'h2; rg[2] = 4'h3; rg[3] = 4'h4;
        send_word(1'b1, 1'b1, 1'b0);
        begin
            int n = 0;
            while (sb.size() > 2 && n < 100) begin
                @(negedge clk);
                n++;
            end
            chk("reach_range_phase", {31'd0, (sb.size() == 2)}, 32'd1);
        end
        set_word("q");
        for (int i = 0; i < int'(WML); i++) bus.din[i*CB +: CB] = ch[i];
        bus.wr_en = 1'b1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        sb.delete();
        chk("rst_mid_full", {31'd0, bus.full}, 32'd0);
        chk("rst_mid_dout", {24'd0, bus.dout}, 32'd0);
        chk("rst_mid_dout_wr_en", {31'd0, bus.dout_wr_en}, 32'd0);
        chk("rst_mid_pkt_end", {31'd0, bus.pkt_end}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        bus.wr_en = 1'b0;
        @(negedge clk);
        chk("rst_beats_wr_en", {31'd0, bus.full}, 32'd0);
        set_word("xyz");
        send_word(1'b0, 1'b1, 1'b1);
        drain();

        // Random words under random backpressure
        stall_en = 1'b1;
        for (int w = 0; w < 150; w++) begin
            int len, nr;
            bit tmpl, last;
            len = $urandom_range(0, WML);
            nr  = $urandom_range(0, RM);
            for (int i = 0; i < int'(WML); i++) ch[i] = CB'($urandom_range(0, 255));
            for (int i = 0; i < len; i++) ch[i] = CB'($urandom_range(1, 255));
            if (len < int'(WML)) ch[len] = '0;
            for (int j = 0; j < int'(RM); j++) rg[j] = (RMSB+1)'($urandom_range(0, 15));
            for (int j = 0; j < nr; j++) rg[j] = (RMSB+1)'($urandom_range(1, 15));
            if (nr < int'(RM)) rg[nr] = '0;
            tmpl = 1'($urandom);
            last = ($urandom_range(0, 3) == 0);
            send_word(tmpl, last, 1'b0);
        end
        stall_en = 1'b0;
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
